// File: rtl/stb_blink_multi_if.sv
// Handshake bundle for stb_blink_multi.
//   mode  : behaviour select, sampled by a channel when it leaves idle
//   stb   : per-channel single-cycle event strobes
//   blink : per-channel registered LED drive
//   busy  : per-channel registered "not idle" flag
// master drives mode/stb (event source side); slave is the blinker.
interface stb_blink_multi_if #(
    parameter int unsigned CHANNELS = 4
) ();
    logic [1:0]          mode;
    logic [CHANNELS-1:0] stb;
    logic [CHANNELS-1:0] blink;
    logic [CHANNELS-1:0] busy;

    modport master (
        output mode,
        output stb,
        input  blink,
        input  busy
    );

    modport slave (
        input  mode,
        input  stb,
        output blink,
        output busy
    );
endinterface

// File: rtl/stb_blink_multi.sv
// Multi-channel strobe-to-LED pulse generator. Each channel runs its own
// IDLE/ON/OFF machine and turns single-cycle strobes into visible blinks.
// Behaviour per channel is picked by bus.mode when the channel starts:
//   0 retriggerable stretch, 1 one-shot, 2 fixed pulse train,
//   3 event-counting blink (one blink per queued strobe).
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset (aborts all channels)
//   bus : slave modport -- mode/stb in, registered blink/busy out
module stb_blink_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned COUNT    = 120000,
    parameter int unsigned GAP      = 120000,
    parameter int unsigned PULSES   = 3,
    parameter int unsigned PEND_MAX = 15
) (
    input logic               clk,
    input logic               rst,
    stb_blink_multi_if.slave  bus
);

    localparam int unsigned CntMax = (COUNT > GAP) ? COUNT : GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned PlftW  = $clog2(PULSES + 1);
    localparam int unsigned PendW  = $clog2(PEND_MAX + 1);

    localparam logic [CntW-1:0]  CountLd = CntW'(COUNT - 1);
    localparam logic [CntW-1:0]  GapLd   = CntW'(GAP - 1);
    localparam logic [PlftW-1:0] PlftLd  = PlftW'(PULSES - 1);
    localparam logic [PendW-1:0] PendSat = PendW'(PEND_MAX);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    state_e           state_q [CHANNELS];
    state_e           state_d [CHANNELS];
    logic [CntW-1:0]  cnt_q   [CHANNELS];
    logic [CntW-1:0]  cnt_d   [CHANNELS];
    logic [1:0]       lmode_q [CHANNELS];
    logic [1:0]       lmode_d [CHANNELS];
    logic [PlftW-1:0] plft_q  [CHANNELS];
    logic [PlftW-1:0] plft_d  [CHANNELS];
    logic [PendW-1:0] pend_q  [CHANNELS];
    logic [PendW-1:0] pend_d  [CHANNELS];
    logic             pend_inc [CHANNELS];
    logic             pend_dec [CHANNELS];

    logic [CHANNELS-1:0] blink_q, blink_d;
    logic [CHANNELS-1:0] busy_q, busy_d;

    always_comb begin
        blink_d = '0;
        busy_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            lmode_d[i]  = lmode_q[i];
            plft_d[i]   = plft_q[i];
            pend_d[i]   = pend_q[i];
            pend_inc[i] = 1'b0;
            pend_dec[i] = 1'b0;

            unique case (state_q[i])
                StIdle: begin
                    if (bus.stb[i]) begin
                        lmode_d[i] = bus.mode;
                        cnt_d[i]   = CountLd;
                        plft_d[i]  = PlftLd;
                        pend_d[i]  = '0;
                        state_d[i] = StOn;
                    end
                end
                StOn: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end else begin
                        unique case (lmode_q[i])
                            2'd2: begin
                                if (plft_q[i] == '0) begin
                                    state_d[i] = StIdle;
                                end else begin
                                    plft_d[i]  = plft_q[i] - 1'b1;
                                    cnt_d[i]   = GapLd;
                                    state_d[i] = StOff;
                                end
                            end
                            2'd3: begin
                                cnt_d[i]   = GapLd;
                                state_d[i] = StOff;
                            end
                            default: state_d[i] = StIdle;
                        endcase
                    end
                    // Strobe handling overrides the expiry decision above, so a
                    // mode-0 strobe on the last ON cycle keeps the channel lit.
                    if (bus.stb[i]) begin
                        if (lmode_q[i] == 2'd0) begin
                            cnt_d[i]   = CountLd;
                            state_d[i] = StOn;
                        end else if (lmode_q[i] == 2'd3) begin
                            pend_inc[i] = 1'b1;
                        end
                    end
                end
                StOff: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end else if (lmode_q[i] == 2'd2) begin
                        cnt_d[i]   = CountLd;
                        state_d[i] = StOn;
                    end else if (lmode_q[i] == 2'd3 && pend_q[i] != '0) begin
                        pend_dec[i] = 1'b1;
                        cnt_d[i]    = CountLd;
                        state_d[i]  = StOn;
                    end else begin
                        state_d[i] = StIdle;
                    end
                    if (bus.stb[i] && lmode_q[i] == 2'd3) begin
                        pend_inc[i] = 1'b1;
                    end
                end
                default: state_d[i] = StIdle;
            endcase

            // A strobe landing on the cycle a queued event is consumed cancels
            // out, even when the counter is already saturated.
            if (pend_inc[i] && !pend_dec[i]) begin
                pend_d[i] = (pend_q[i] == PendSat) ? PendSat : pend_q[i] + 1'b1;
            end else if (pend_dec[i] && !pend_inc[i]) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end

            blink_d[i] = (state_d[i] == StOn);
            busy_d[i]  = (state_d[i] != StIdle);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                lmode_q[i] <= '0;
                plft_q[i]  <= '0;
                pend_q[i]  <= '0;
            end
            blink_q <= '0;
            busy_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                lmode_q[i] <= lmode_d[i];
                plft_q[i]  <= plft_d[i];
                pend_q[i]  <= pend_d[i];
            end
            blink_q <= blink_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.blink = blink_q;
    assign bus.busy  = busy_q;

endmodule
